// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch controller: queue entry layout and redirect sources.
// Optional feature macro used by fetch_ctrl: FETCH_BYPASS_EN.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        exception;
        logic [7:0]  mcause;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        NONE,
        EXC,
        MRET,
        MISPRED
    } redirect_src_t;

    // Trap entry beats trap return, which beats a branch correction.
    function automatic redirect_src_t redirect_sel(
        input logic exc,
        input logic ret,
        input logic mis
    );
        if (exc) return EXC;
        if (ret) return MRET;
        if (mis) return MISPRED;
        return NONE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer of fetch entries.
// Synchronous flush takes priority over push and pop.
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic         empty,
    output logic [AW:0]  count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: credit-limited requests, fetch queue, redirects.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exception,
    input  logic [31:0] mtvec_ReadData,
    input  logic        mret,
    input  logic [31:0] mepc_ReadData,
    input  logic        mispredicted,
    input  logic [31:0] pc_update,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    input  logic        imem_exception,
    input  logic [7:0]  imem_mcause,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_pc,
    output logic [31:0] fq_instruction,
    output logic        fq_exception,
    output logic [7:0]  fq_mcause
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 2;

    logic [0:0]    state;
    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    redirect_src_t src;
    logic          redirect;
    logic [31:0]   target;
    logic          resp_valid;
    logic          resp_exc;
    logic          credit_ok;
    fetch_entry_t  resp;
    fetch_entry_t  head;
    fetch_entry_t  fifo_dout;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    always_comb begin
        src      = redirect_sel(exception, mret, mispredicted);
        redirect = (src != NONE);
        unique case (src)
            EXC:     target = mtvec_ReadData;
            MRET:    target = mepc_ReadData;
            MISPRED: target = pc_update;
            default: target = pc;
        endcase
    end

    // A redirect kills the response of the previous cycle's request.
    assign resp_valid = inflight && !redirect;
    assign resp_exc   = resp_valid && imem_exception;
    assign resp       = '{pc: inflight_pc, instruction: imem_instruction,
                          exception: imem_exception, mcause: imem_mcause};

    assign credit_ok = (CW'(fifo_count) + CW'(inflight)) < CW'(FQ_DEPTH);
    assign imem_req  = !reset && (state == RUN) && !redirect
                       && !resp_exc && credit_ok;
    assign imem_addr = pc;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass   = resp_valid && fifo_empty;
    assign push     = resp_valid && !(bypass && fq_ready);
    assign pop      = !fifo_empty && fq_ready;
    assign fq_valid = !fifo_empty || bypass;
    assign head     = fifo_empty ? resp : fifo_dout;
`else
    assign push     = resp_valid;
    assign pop      = !fifo_empty && fq_ready;
    assign fq_valid = !fifo_empty;
    assign head     = fifo_dout;
`endif

    assign fq_pc          = fq_valid ? head.pc : '0;
    assign fq_instruction = fq_valid ? head.instruction : '0;
    assign fq_exception   = fq_valid && head.exception;
    assign fq_mcause      = fq_valid ? head.mcause : '0;

    fetch_fifo #(
        .DEPTH(FQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .din   (resp),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight    <= imem_req;
            inflight_pc <= pc;
            if (redirect) begin
                state <= RUN;
                pc    <= target;
            end else begin
                if (resp_exc) state <= HOLD;
                if (imem_req) pc <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based model of the fetch stream.
module tb_fetch_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic        exc;
        logic [7:0]  mc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exception = 1'b0;
    logic [31:0] mtvec_ReadData = '0;
    logic        mret = 1'b0;
    logic [31:0] mepc_ReadData = '0;
    logic        mispredicted = 1'b0;
    logic [31:0] pc_update = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction = '0;
    logic        imem_exception = 1'b0;
    logic [7:0]  imem_mcause = '0;
    logic        fq_valid;
    logic        fq_ready = 1'b0;
    logic [31:0] fq_pc;
    logic [31:0] fq_instruction;
    logic        fq_exception;
    logic [7:0]  fq_mcause;

    int tests = 0;
    int fails = 0;

    ent_t        exp_q[$];
    logic [31:0] model_pc;
    logic        hold_m;
    logic        last_req;
    logic [31:0] last_addr;
    logic        exc_en = 1'b0;
    logic [31:0] exc_addr = '0;
    logic        exc_rand = 1'b0;

    logic        s_req, s_valid, s_exc, s_redir;
    logic [31:0] s_addr, s_pc, s_instr;
    logic [7:0]  s_mc;
    logic [31:0] m_addr;
    logic        m_hold;
    int          m_size;
    ent_t        m_head;

    fetch_ctrl #(.FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .exception(exception), .mtvec_ReadData(mtvec_ReadData),
        .mret(mret), .mepc_ReadData(mepc_ReadData),
        .mispredicted(mispredicted), .pc_update(pc_update),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_instruction(imem_instruction), .imem_exception(imem_exception),
        .imem_mcause(imem_mcause),
        .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_pc(fq_pc),
        .fq_instruction(fq_instruction), .fq_exception(fq_exception),
        .fq_mcause(fq_mcause)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        model_pc  = RPC;
        hold_m    = 1'b0;
        last_req  = 1'b0;
        last_addr = '0;
    endtask

    // One cycle, entered at a negedge: behave as imem, sample DUT, advance model.
    task automatic tick();
        logic       r_exc;
        logic [7:0] r_mc;
        logic       redir;
        r_exc = 1'b0;
        r_mc  = '0;
        if (last_req) begin
            if (exc_rand) r_exc = ($urandom_range(0, 40) == 0);
            else r_exc = exc_en && (last_addr == exc_addr);
            if (r_exc) r_mc = exc_rand ? 8'($urandom_range(1, 15)) : 8'd1;
        end
        imem_instruction = ifn(last_addr);
        imem_exception   = r_exc;
        imem_mcause      = r_mc;
        redir = exception || mret || mispredicted;
        if (last_req && !redir) exp_q.push_back('{last_addr, r_exc, r_mc});
        m_addr = model_pc;
        m_hold = hold_m;
        m_size = exp_q.size();
        m_head = (m_size > 0) ? exp_q[0] : '{32'h0, 1'b0, 8'h0};
        s_redir = redir;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = fq_valid;
        s_pc    = fq_pc;
        s_instr = fq_instruction;
        s_exc   = fq_exception;
        s_mc    = fq_mcause;
        @(posedge clk);
        if (redir) begin
            exp_q.delete();
            hold_m = 1'b0;
            model_pc = exception ? mtvec_ReadData :
                       mret ? mepc_ReadData : pc_update;
        end else begin
            if (last_req && r_exc) hold_m = 1'b1;
            if (s_valid && fq_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (s_req) model_pc = model_pc + 32'd4;
        end
        last_req  = s_req;
        last_addr = s_addr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exception = 1'b0;
        mret = 1'b0;
        mispredicted = 1'b0;
        fq_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests++; if (fq_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", fq_valid); end
        tests++; if (fq_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", fq_pc); end
        tests++; if (fq_instruction !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", fq_instruction); end
        tests++; if (fq_exception !== 1'b0) begin fails++; $display("FAIL reset_exc: got %b want 0", fq_exception); end
        tests++; if (fq_mcause !== 8'h0) begin fails++; $display("FAIL reset_mcause: got %h want 0", fq_mcause); end
    endtask

    task automatic test_sequential();
        logic [31:0] reqs[$];
        logic [31:0] dels[$];
        logic [31:0] want;
        do_reset();
        fq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_req) reqs.push_back(s_addr);
            if (i < 3) begin
                tests++;
                if (s_req !== 1'b1) begin fails++; $display("FAIL seq_req%0d: got %b want 1", i, s_req); end
            end
            if (s_valid) begin
                dels.push_back(s_pc);
                tests++;
                if (s_instr !== ifn(s_pc)) begin fails++; $display("FAIL seq_instr: got %h want %h", s_instr, ifn(s_pc)); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            want = RPC + 32'(4 * i);
            tests++;
            if (reqs.size() <= i || reqs[i] !== want) begin
                fails++; $display("FAIL seq_addr%0d: got %h want %h", i, (reqs.size() > i) ? reqs[i] : 32'hx, want);
            end
            tests++;
            if (dels.size() <= i || dels[i] !== want) begin
                fails++; $display("FAIL seq_fqpc%0d: got %h want %h", i, (dels.size() > i) ? dels[i] : 32'hx, want);
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        int ndel;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_req) nreq++;
            if (s_valid) begin
                tests++;
                if (s_pc !== RPC || s_instr !== ifn(RPC)) begin
                    fails++; $display("FAIL bp_hold: got %h/%h want %h/%h", s_pc, s_instr, RPC, ifn(RPC));
                end
            end
        end
        tests++; if (nreq != DEPTH) begin fails++; $display("FAIL bp_count: got %0d want %0d", nreq, DEPTH); end
        tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL bp_stall: got %b want 0", s_req); end
        fq_ready = 1'b1;
        ndel = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_valid) begin
                tests++;
                if (s_pc !== RPC + 32'(4 * ndel)) begin
                    fails++; $display("FAIL bp_drain%0d: got %h want %h", ndel, s_pc, RPC + 32'(4 * ndel));
                end
                ndel++;
            end
        end
        tests++; if (ndel < 8) begin fails++; $display("FAIL bp_drain_count: got %0d want >=8", ndel); end
    endtask

    task automatic test_mispredict();
        int ndel;
        logic bad;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        mispredicted = 1'b1;
        pc_update = 32'h0000_1000;
        tick();
        tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL mis_req_cut: got %b want 0", s_req); end
        mispredicted = 1'b0;
        fq_ready = 1'b1;
        tick();
        tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL mis_flush: got %b want 0", s_valid); end
        tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_1000) begin
            fails++; $display("FAIL mis_target: got %b/%h want 1/00001000", s_req, s_addr);
        end
        ndel = 0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_valid) begin
                if (s_pc !== 32'h0000_1000 + 32'(4 * ndel)) bad = 1'b1;
                ndel++;
            end
        end
        tests++; if (bad || ndel == 0) begin fails++; $display("FAIL mis_stale: got bad=%b n=%0d want clean", bad, ndel); end
    endtask

    task automatic test_priority();
        exception = 1'b1; mtvec_ReadData = 32'h100;
        mret = 1'b1;      mepc_ReadData = 32'h200;
        mispredicted = 1'b1; pc_update = 32'h300;
        tick();
        tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL prio_req_cut: got %b want 0", s_req); end
        exception = 1'b0; mret = 1'b0; mispredicted = 1'b0;
        tick();
        tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            fails++; $display("FAIL prio_target: got %b/%h want 1/00000100", s_req, s_addr);
        end
        mret = 1'b1; mispredicted = 1'b1;
        tick();
        mret = 1'b0; mispredicted = 1'b0;
        tick();
        tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            fails++; $display("FAIL prio_mret: got %b/%h want 1/00000200", s_req, s_addr);
        end
    endtask

    task automatic test_fetch_exception();
        int  nreq;
        logic seen;
        do_reset();
        fq_ready = 1'b1;
        exc_en = 1'b1;
        exc_addr = RPC + 32'd8;
        nreq = 0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_req) nreq++;
            if (s_valid && s_pc == exc_addr) begin
                seen = 1'b1;
                tests++;
                if (s_exc !== 1'b1 || s_mc !== 8'd1) begin
                    fails++; $display("FAIL fexc_payload: got %b/%h want 1/01", s_exc, s_mc);
                end
            end
        end
        tests++; if (!seen) begin fails++; $display("FAIL fexc_delivered: got 0 want 1"); end
        tests++; if (nreq != 3) begin fails++; $display("FAIL fexc_hold: got %0d reqs want 3", nreq); end
        exc_en = 1'b0;
        exception = 1'b1;
        mtvec_ReadData = 32'h0000_2000;
        tick();
        exception = 1'b0;
        tick();
        tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_2000) begin
            fails++; $display("FAIL fexc_trap: got %b/%h want 1/00002000", s_req, s_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] reqs[$];
        logic [31:0] want[3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        fq_ready = 1'b1;
        mispredicted = 1'b1;
        pc_update = 32'hFFFF_FFF8;
        tick();
        mispredicted = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_req) reqs.push_back(s_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (reqs.size() <= i || reqs[i] !== want[i]) begin
                fails++; $display("FAIL wrap%0d: got %h want %h", i, (reqs.size() > i) ? reqs[i] : 32'hx, want[i]);
            end
        end
        reset = 1'b1;
        #1;
        tests++; if (fq_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", fq_valid); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_req: got %b want 0", imem_req); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        tests++;
        if (s_req !== 1'b1 || s_addr !== RPC || s_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_restart: got %b/%h/%b want 1/%h/0", s_req, s_addr, s_valid, RPC);
        end
    endtask

    task automatic test_random();
        int kind;
        do_reset();
        exc_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            fq_ready = ($urandom_range(0, 9) < 7);
            exception = 1'b0; mret = 1'b0; mispredicted = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                kind = $urandom_range(0, 2);
                mtvec_ReadData = $urandom & 32'hFFFF_FFFC;
                mepc_ReadData  = $urandom & 32'hFFFF_FFFC;
                pc_update      = $urandom & 32'hFFFF_FFFC;
                exception    = (kind == 0) || ($urandom_range(0, 3) == 0 && kind != 0 && 1'b0);
                mret         = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
                mispredicted = (kind == 2) || ($urandom_range(0, 1) == 1);
            end
            tick();
            if (s_req) begin
                tests++;
                if (s_addr !== m_addr) begin fails++; $display("FAIL rnd_addr: got %h want %h", s_addr, m_addr); end
                tests++;
                if (m_size >= DEPTH || m_hold || s_redir) begin
                    fails++; $display("FAIL rnd_req_illegal: got req=1 occ=%0d hold=%b redir=%b want req=0", m_size, m_hold, s_redir);
                end
            end
            if (s_valid) begin
                tests++;
                if (m_size == 0) begin
                    fails++; $display("FAIL rnd_valid_empty: got valid=1 want 0");
                end else if (s_pc !== m_head.pc || s_instr !== ifn(m_head.pc)
                             || s_exc !== m_head.exc || s_mc !== m_head.mc) begin
                    fails++;
                    $display("FAIL rnd_head: got %h/%h/%b/%h want %h/%h/%b/%h", s_pc, s_instr, s_exc, s_mc,
                             m_head.pc, ifn(m_head.pc), m_head.exc, m_head.mc);
                end
            end
        end
        exc_rand = 1'b0;
        exception = 1'b0; mret = 1'b0; mispredicted = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_mispredict();
        test_priority();
        test_fetch_exception();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports exception  input  1 and mtvec_ReadData  input  32: trap redirect and its target.
REQ-006 SHALL have ports mret  input  1 and mepc_ReadData  input  32: trap return and its target.
REQ-007 SHALL have ports mispredicted  input  1 and pc_update  input  32: branch redirect and corrected PC.
REQ-008 SHALL have ports imem_req  output  1 and imem_addr  output  32: fetch request to instruction memory.
REQ-009 SHALL have ports imem_instruction  input  32, imem_exception  input  1 and imem_mcause  input  8: response, valid exactly one cycle after imem_req.
REQ-010 SHALL have ports fq_valid  output  1 and fq_ready  input  1: decode-side valid/ready handshake.
REQ-011 SHALL have ports fq_pc  output  32, fq_instruction  output  32, fq_exception  output  1 and fq_mcause  output  8: head-entry payload.

Function
REQ-012 SHALL use FSM states RUN (fetching) and HOLD (fetch exception queued; no new requests).
REQ-013 SHALL assert imem_req in RUN only when queue occupancy plus in-flight requests < FQ_DEPTH (credit rule), so the queue never overflows.
REQ-014 SHALL increment fetch PC by 4 on each issued request; PC wraps from 32'hFFFF_FFFC to 0.
REQ-015 SHALL enqueue {request PC, imem_instruction, imem_exception, imem_mcause} on the cycle after each surviving request.
REQ-016 SHALL move RUN->HOLD when an enqueued response has imem_exception=1; no requests are issued in HOLD.
REQ-017 SHALL apply redirect priority exception > mret > mispredicted; only the highest-priority target is used.
REQ-018 On any redirect SHALL, in the same edge: flush all queue entries, discard the in-flight response, load fetch PC with the target, and enter RUN; the next imem_req addresses the target.
REQ-019 SHALL deassert imem_req in the redirect cycle itself; redirect overrides any same-cycle enqueue or dequeue.
REQ-020 SHALL dequeue the head on fq_valid & fq_ready; simultaneous enqueue and dequeue at full is legal and occupancy is unchanged.
REQ-021 SHALL keep fq_* payload stable while fq_valid=1 and fq_ready=0.
REQ-022 SHALL drive fq_valid=0 whenever the queue is empty (subject to REQ-026).

Reset
REQ-023 On reset assertion SHALL asynchronously set: fetch PC=RESET_PC, state=RUN, occupancy=0, in-flight=0, imem_req=0, fq_valid=0, fq_pc=0, fq_instruction=0, fq_exception=0, fq_mcause=0.
REQ-024 SHALL issue the first imem_req (imem_addr=RESET_PC) on the first cycle after reset deasserts.
REQ-025 Reset asserted mid-operation SHALL discard queued and in-flight fetches with no residual fq_valid.

Configuration
REQ-026 With FETCH_BYPASS_EN defined, a response arriving while the queue is empty SHALL appear on fq_* in the same cycle (fq_valid=1) and is not written if fq_ready=1; without it, every response is written first and fq_valid rises one cycle later.

Structure
REQ-027 Shared package SHALL hold RESET_PC default, typedef fetch_entry_t {pc, instruction, exception, mcause}, and enum redirect_src_t {NONE, EXC, MRET, MISPRED}.
REQ-028 The queue SHALL be a sub-module fetch_fifo (parameterised depth, fetch_entry_t payload, synchronous flush).

Verification
REQ-029 Reset release, fq_ready=1 -> imem_addr 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; fq_pc follows the same sequence.
REQ-030 fq_ready=0 for 10 cycles -> exactly FQ_DEPTH=4 requests issued, then imem_req=0; fq_payload held; release -> in-order drain.
REQ-031 mispredicted=1, pc_update=0000_1000 with 3 queued entries and 1 in flight -> fq_valid=0 next cycle, next imem_addr=0000_1000, stale response never appears.
REQ-032 exception, mret and mispredicted all asserted together (targets 100, 200, 300) -> next imem_addr=0000_0100.
REQ-033 imem_exception=1, imem_mcause=8'd1 at PC 8000_0008 -> entry delivered with fq_exception=1, fq_mcause=1; imem_req stays 0 until exception redirect to mtvec_ReadData.
REQ-034 Fetch PC at FFFF_FFFC -> next imem_addr 0000_0000; reset pulsed mid-stream -> fq_valid=0 immediately, restart at RESET_PC.
